// File: rtl/attn_pkg.sv
// Shared types and default sizing for the attention engine and its host bridge.
package attn_pkg;

    // Default geometry shared with the engine.
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_SEQ_LEN    = 64;
    localparam int DEF_EMBED_DIM  = 64;
    localparam int DEF_TIMEOUT    = 2**20;

    // One token is EMBED_DIM elements of DATA_WIDTH bits, element 0 in the low bits.
    localparam int TOKEN_W = DEF_DATA_WIDTH * DEF_EMBED_DIM;

    // Bridge sequencing: load tokens, reset engine, start engine, wait, stream results.
    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_CLR   = 3'd1,
        ST_FIRE  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } bridge_state_e;

endpackage

// File: rtl/attn_token_bridge_if.sv
// Token stream interface between a host and the attention bridge.
//
// Valid/ready: a beat transfers on a rising clk edge where valid and ready are
// both high. The sender keeps valid high and its payload unchanged until that
// beat transfers; ready may be high or low independently of valid.
interface attn_token_bridge_if #(
    parameter int W = attn_pkg::TOKEN_W
);
    // Host to bridge token stream.
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_token;

    // Bridge to host token stream.
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_token;
    logic         out_last;

    // Host side: sends input tokens, consumes output tokens.
    modport master (
        output in_valid, in_token, out_ready,
        input  in_ready, out_valid, out_token, out_last
    );

    // Bridge side: consumes input tokens, sends output tokens.
    modport slave (
        input  in_valid, in_token, out_ready,
        output in_ready, out_valid, out_token, out_last
    );
endinterface

// File: rtl/attn_token_bridge.sv
// Host-side front end for the self-attention engine: collects SEQ_LEN tokens,
// runs the engine through a reset/start/done cycle, then streams the result back.
module attn_token_bridge
    import attn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SEQ_LEN    = DEF_SEQ_LEN,
    parameter int EMBED_DIM  = DEF_EMBED_DIM,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                                    clk,
    input  logic                                    rst,
    attn_token_bridge_if.slave                      tok,
    output logic                                    attn_rst,
    output logic                                    attn_start,
    input  logic                                    attn_done,
    output logic [DATA_WIDTH*SEQ_LEN*EMBED_DIM-1:0] attn_input_flat,
    input  logic [DATA_WIDTH*SEQ_LEN*EMBED_DIM-1:0] attn_output_flat,
    output logic                                    busy,
    output logic                                    timeout_err,
    output bridge_state_e                           state_dbg
);

    localparam int TOK_W  = DATA_WIDTH * EMBED_DIM;
    localparam int IDX_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SEQ_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    bridge_state_e     state;
    bridge_state_e     state_nxt;
    logic [IDX_W-1:0]  in_idx;
    logic [IDX_W-1:0]  out_idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [TOK_W-1:0]  in_buf  [SEQ_LEN];
    logic [TOK_W-1:0]  out_buf [SEQ_LEN];

    logic in_fire;
    logic out_fire;
    logic wait_expired;

    // Handshakes only count in the state that owns the stream; rst overrides both in the registers.
    assign in_fire      = (state == ST_LOAD)  && tok.in_valid;
    assign out_fire     = (state == ST_DRAIN) && tok.out_ready;
    assign wait_expired = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    assign state_dbg     = state;
    assign tok.out_token = out_buf[out_idx];

    // The engine sees the input buffer directly; it only changes during LOAD.
    for (genvar k = 0; k < SEQ_LEN; k++) begin : g_flat
        assign attn_input_flat[k*TOK_W +: TOK_W] = in_buf[k];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_nxt;
    end

    // Next-state: done wins over the watchdog in WAIT; done is ignored elsewhere.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:  if (in_fire && (in_idx == LAST_IDX))    state_nxt = ST_CLR;
            ST_CLR:                                            state_nxt = ST_FIRE;
            ST_FIRE:                                           state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (attn_done)         state_nxt = ST_DRAIN;
                else if (wait_expired) state_nxt = ST_LOAD;
            end
            ST_DRAIN: if (out_fire && (out_idx == LAST_IDX))  state_nxt = ST_DRAIN == ST_DRAIN ? ST_LOAD : ST_LOAD;
            default:                                           state_nxt = ST_LOAD;
        endcase
    end

    // Outputs decoded from state; everything host-visible is quiet while rst is high.
    always_comb begin
        tok.in_ready  = 1'b0;
        tok.out_valid = 1'b0;
        tok.out_last  = 1'b0;
        attn_start    = 1'b0;
        busy          = 1'b0;
        attn_rst      = rst || (state == ST_CLR);
        if (!rst) begin
            tok.in_ready  = (state == ST_LOAD);
            tok.out_valid = (state == ST_DRAIN);
            tok.out_last  = (state == ST_DRAIN) && (out_idx == LAST_IDX);
            attn_start    = (state == ST_FIRE);
            busy          = (state != ST_LOAD);
        end
    end

    // Index counters, engine watchdog and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_idx      <= '0;
            out_idx     <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (in_fire)  in_idx  <= (in_idx  == LAST_IDX) ? '0 : in_idx  + 1'b1;
            if (out_fire) out_idx <= (out_idx == LAST_IDX) ? '0 : out_idx + 1'b1;
            if ((state == ST_WAIT) && !attn_done) begin
                if (wait_expired) begin
                    wait_cnt    <= '0;
                    timeout_err <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Data buffers carry no reset: contents are only meaningful once written.
    always_ff @(posedge clk) begin
        if (in_fire) in_buf[in_idx] <= tok.in_token;
        if ((state == ST_WAIT) && attn_done) begin
            for (int k = 0; k < SEQ_LEN; k++) begin
                out_buf[k] <= attn_output_flat[k*TOK_W +: TOK_W];
            end
        end
    end

endmodule

// File: tb/tb_attn_token_bridge.sv
// Directed bench for attn_token_bridge with a behavioural engine that returns element+1.
module tb_attn_token_bridge;
    import attn_pkg::*;

    localparam int DW = 16;
    localparam int SL = 4;
    localparam int ED = 2;
    localparam int TO = 16;
    localparam int TW = DW * ED;
    localparam int FW = TW * SL;

    logic          clk = 1'b0;
    logic          rst;
    logic          attn_rst;
    logic          attn_start;
    logic          attn_done;
    logic [FW-1:0] attn_input_flat;
    logic [FW-1:0] attn_output_flat;
    logic          busy;
    logic          timeout_err;
    bridge_state_e state_dbg;

    attn_token_bridge_if #(.W(TW)) tok ();

    attn_token_bridge #(
        .DATA_WIDTH(DW), .SEQ_LEN(SL), .EMBED_DIM(ED), .TIMEOUT(TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tok              (tok),
        .attn_rst         (attn_rst),
        .attn_start       (attn_start),
        .attn_done        (attn_done),
        .attn_input_flat  (attn_input_flat),
        .attn_output_flat (attn_output_flat),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .state_dbg        (state_dbg)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- engine model ----------------
    bit         eng_hang = 1'b0;
    logic       eng_run;
    logic [3:0] eng_cnt;

    function automatic logic [FW-1:0] plus1(input logic [FW-1:0] v);
        logic [FW-1:0] r;
        r = '0;
        for (int i = 0; i < SL*ED; i++) r[i*DW +: DW] = v[i*DW +: DW] + 16'd1;
        return r;
    endfunction

    // Done rises eight edges after the start edge and stays high until attn_rst.
    always @(posedge clk) begin
        if (attn_rst) begin
            attn_done <= 1'b0;
            eng_run   <= 1'b0;
            eng_cnt   <= 4'd0;
        end else if (attn_start) begin
            eng_run <= !eng_hang;
            eng_cnt <= 4'd1;
        end else if (eng_run) begin
            if (eng_cnt == 4'd8) begin
                attn_done        <= 1'b1;
                eng_run          <= 1'b0;
                attn_output_flat <= plus1(attn_input_flat);
            end else begin
                eng_cnt <= eng_cnt + 4'd1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [TW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h required %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    int rst_pulse_cnt, rst_pulse_cyc, start_pulse_cnt, start_cyc;
    int accept_cnt, last_acc_edge, beat_cnt, first_valid_cyc, done_first_cyc, to_cyc;
    int beat_idx = 0;
    bit stall_prev = 1'b0;
    bit post_last = 1'b0;
    logic [TW-1:0] stall_tok;

    task automatic clear_marks();
        rst_pulse_cnt = 0; rst_pulse_cyc = -1; start_pulse_cnt = 0; start_cyc = -1;
        accept_cnt = 0; last_acc_edge = -1; beat_cnt = 0;
        first_valid_cyc = -1; done_first_cyc = -1; to_cyc = -1;
    endtask

    // Monitor samples on the falling edge; a handshake seen here transfers at the next rising edge.
    always begin
        @(negedge clk);
        if (rst) begin
            beat_idx   = 0;
            stall_prev = 1'b0;
            post_last  = 1'b0;
        end else begin
            if (post_last) begin
                check_eq("in_ready_after_last", tok.in_ready, 1);
                post_last = 1'b0;
            end
            if (stall_prev) begin
                check_eq("stall_valid", tok.out_valid, 1);
                check_eq("stall_token", tok.out_token, stall_tok);
            end
            if (attn_rst) begin rst_pulse_cnt++; rst_pulse_cyc = cyc; end
            if (attn_start) begin start_pulse_cnt++; start_cyc = cyc; end
            if (attn_done && done_first_cyc < 0) done_first_cyc = cyc;
            if (timeout_err && to_cyc < 0) to_cyc = cyc;
            if (tok.in_valid && tok.in_ready) begin accept_cnt++; last_acc_edge = cyc + 1; end
            if (tok.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (tok.out_valid && tok.out_ready) begin
                beat_cnt++;
                check_eq("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check_eq("out_token", tok.out_token, exp_q.pop_front());
                    check_eq("out_last", tok.out_last, beat_idx == SL-1);
                end
                if (tok.out_last) post_last = 1'b1;
                beat_idx   = (beat_idx == SL-1) ? 0 : beat_idx + 1;
                stall_prev = 1'b0;
            end else begin
                stall_prev = tok.out_valid;
                stall_tok  = tok.out_token;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_token(input logic [TW-1:0] t);
        int n = 0;
        tok.in_valid = 1'b1;
        tok.in_token = t;
        @(negedge clk);
        while (!tok.in_ready && n < 200) begin @(negedge clk); n++; end
        if (!tok.in_ready) check_eq("in_ready_wait", tok.in_ready, 1);
        step();
        tok.in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [15:0] base, input bit gaps, input bit push);
        for (int k = 0; k < SL; k++) begin
            logic [15:0] e0, e1;
            e0 = base + 16'(2*k + 1);
            e1 = base + 16'(2*k + 2);
            if (push) exp_q.push_back({e1 + 16'd1, e0 + 16'd1});
            drive_token({e1, e0});
            if (gaps && k != SL-1) step();
        end
    endtask

    task automatic check_flat(input logic [15:0] base);
        @(negedge clk);
        for (int k = 0; k < SL; k++) begin
            logic [TW-1:0] t;
            t = attn_input_flat[k*TW +: TW];
            check_eq("input_flat", t, {base + 16'(2*k + 2), base + 16'(2*k + 1)});
        end
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (beat_cnt < n && k < 200) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        check_eq("drain_beats", beat_cnt, n);
        check_eq("queue_empty", exp_q.size(), 0);
    endtask

    task automatic wait_valid();
        int k = 0;
        @(negedge clk);
        while (!tok.out_valid && k < 100) begin @(negedge clk); k++; end
        if (!tok.out_valid) check_eq("out_valid_wait", tok.out_valid, 1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst = 1'b1;
        tok.in_valid  = 1'b0;
        tok.in_token  = '0;
        tok.out_ready = 1'b0;
        clear_marks();

        // Reset state
        step();
        @(negedge clk);
        check_eq("rst_in_ready", tok.in_ready, 0);
        check_eq("rst_out_valid", tok.out_valid, 0);
        check_eq("rst_out_last", tok.out_last, 0);
        check_eq("rst_attn_start", attn_start, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_attn_rst", attn_rst, 1);
        check_eq("rst_timeout_err", timeout_err, 0);
        check_eq("rst_state", state_dbg, ST_LOAD);
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", tok.in_ready, 1);
        check_eq("post_rst_attn_rst", attn_rst, 0);
        step();

        // Basic round trip
        tok.out_ready = 1'b1;
        clear_marks();
        send_seq(16'h0000, 1'b0, 1'b1);
        check_flat(16'h0000);
        wait_beats(SL);
        check_eq("basic_rst_pulses", rst_pulse_cnt, 1);
        check_eq("basic_start_pulses", start_pulse_cnt, 1);
        check_eq("basic_clr_cycle", rst_pulse_cyc, last_acc_edge);
        check_eq("basic_fire_cycle", start_cyc, last_acc_edge + 1);
        check_eq("basic_done_to_valid", first_valid_cyc, done_first_cyc + 1);
        check_eq("basic_start_to_valid", first_valid_cyc, start_cyc + 10);
        step();

        // Input gaps
        clear_marks();
        send_seq(16'h0100, 1'b1, 1'b1);
        check_flat(16'h0100);
        wait_beats(SL);
        check_eq("gaps_accepts", accept_cnt, SL);
        check_eq("gaps_start_pulses", start_pulse_cnt, 1);
        check_eq("gaps_fire_cycle", start_cyc, last_acc_edge + 1);
        step();

        // Output backpressure
        tok.out_ready = 1'b0;
        clear_marks();
        send_seq(16'h0200, 1'b0, 1'b1);
        wait_valid();
        step();
        tok.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tok.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid", tok.out_valid, 1);
            check_eq("bp_token", tok.out_token, {16'h0207, 16'h0206});
            check_eq("bp_in_ready", tok.in_ready, 0);
            @(posedge clk);
        end
        #1;
        tok.out_ready = 1'b1;
        wait_beats(SL);
        step();

        // Timeout
        eng_hang = 1'b1;
        clear_marks();
        send_seq(16'h0300, 1'b0, 1'b0);
        begin
            int k = 0;
            while (!timeout_err && k < 60) begin @(negedge clk); k++; end
        end
        @(negedge clk);
        check_eq("to_cycle", to_cyc, start_cyc + 17);
        check_eq("to_state", state_dbg, ST_LOAD);
        check_eq("to_in_ready", tok.in_ready, 1);
        check_eq("to_no_valid", first_valid_cyc, -1);
        step();
        eng_hang = 1'b0;
        clear_marks();
        send_seq(16'h0400, 1'b0, 1'b1);
        wait_beats(SL);
        check_eq("to_sticky", timeout_err, 1);
        step();

        // Reset mid-DRAIN
        tok.out_ready = 1'b0;
        clear_marks();
        send_seq(16'h0500, 1'b1, 1'b1);
        wait_valid();
        step();
        tok.out_ready = 1'b1;
        step();
        rst = 1'b1;
        @(negedge clk);
        check_eq("mrst_out_valid", tok.out_valid, 0);
        check_eq("mrst_attn_rst", attn_rst, 1);
        check_eq("mrst_in_ready", tok.in_ready, 0);
        check_eq("mrst_beats", beat_cnt, 1);
        exp_q.delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("mrst_after_valid", tok.out_valid, 0);
        check_eq("mrst_after_in_ready", tok.in_ready, 1);
        check_eq("mrst_after_state", state_dbg, ST_LOAD);
        check_eq("mrst_after_err", timeout_err, 0);
        step();

        // Back-to-back sequences with sticky done in between
        clear_marks();
        send_seq(16'h0600, 1'b1, 1'b1);
        wait_beats(SL);
        step();
        clear_marks();
        send_seq(16'h0700, 1'b1, 1'b1);
        wait_beats(SL);
        check_eq("b2b_rst_pulses", rst_pulse_cnt, 1);
        check_eq("b2b_start_to_valid", first_valid_cyc, start_cyc + 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/attn_token_bridge.md
# attn_token_bridge

Host-side streaming front end for the self-attention engine. Accepts `SEQ_LEN` token vectors one per valid/ready handshake and packs them into the engine's flat input bus. It then resets and starts the engine and waits for `done`. Finally it captures the flat output and streams it back out one token per handshake, acting as the token-stream transmitter/receiver pair around the engine's start/done interface.

## Interface
- `DATA_WIDTH`, 16, bits per element (Q2.14 fixed point, passed through untouched)
- `SEQ_LEN`, 64, tokens per sequence
- `EMBED_DIM`, 64, elements per token
- `TIMEOUT`, 2**20, max WAIT cycles before abort; 0 disables
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  input token valid
- `in_ready`  out  1  bridge accepts input token
- `in_token`  in  DATA_WIDTH*EMBED_DIM  input token vector
- `attn_rst`  out  1  engine reset
- `attn_start`  out  1  engine start pulse
- `attn_done`  in  1  engine done, level, sticky until engine reset
- `attn_input_flat`  out  DATA_WIDTH*SEQ_LEN*EMBED_DIM  packed sequence to engine; token k at bits [k*DATA_WIDTH*EMBED_DIM +: DATA_WIDTH*EMBED_DIM]
- `attn_output_flat`  in  DATA_WIDTH*SEQ_LEN*EMBED_DIM  engine result, same packing
- `out_valid`  out  1  output token valid
- `out_ready`  in  1  consumer accepts output token
- `out_token`  out  DATA_WIDTH*EMBED_DIM  output token vector
- `out_last`  out  1  marks token SEQ_LEN-1
- `busy`  out  1  high in every state except LOAD
- `timeout_err`  out  1  sticky; set on WAIT timeout, cleared only by `rst`

## Operation
- States: LOAD, CLR, FIRE, WAIT, DRAIN.
- LOAD:
  - `in_ready`=1.
  - Each in_valid&in_ready writes `in_token` into input-buffer slice `in_idx`, then increments `in_idx`.
  - The accept with `in_idx`==SEQ_LEN-1 clears `in_idx` and goes to CLR.
- CLR: `attn_rst`=1 for exactly one cycle, clearing the engine's sticky done. Next state is FIRE.
- FIRE: `attn_start`=1 for exactly one cycle. Next state is WAIT.
- WAIT:
  - `wait_cnt` counts cycles.
  - `attn_done`=1: capture `attn_output_flat` into the output buffer at that edge, go to DRAIN.
  - `TIMEOUT`≠0 and `wait_cnt`==TIMEOUT-1 without done: set `timeout_err`, discard the sequence, go to LOAD.
  - `attn_done` is ignored in every state except WAIT.
- DRAIN:
  - `out_valid`=1; `out_token` = output-buffer slice `out_idx`; `out_last` = (`out_idx`==SEQ_LEN-1).
  - Each out_valid&out_ready increments `out_idx`.
  - The handshake with `out_last` clears `out_idx` and goes to LOAD.
- `out_token` is held stable while out_valid&!out_ready.
- `attn_input_flat` is driven straight from the input buffer. The buffer is written only in LOAD, so it is stable from CLR through WAIT.
- No arithmetic on data; all widths pass through bit-exact. Index counters are $clog2(SEQ_LEN) bits wide.

## Timing
- Reset:
  - state=LOAD; `in_idx`, `out_idx`, `wait_cnt`=0; `timeout_err`=0.
  - `attn_rst` = `rst` OR (state==CLR), so the engine is reset with the bridge.
  - During the `rst` cycle: `in_ready`, `attn_start`, `out_valid`, `out_last`, `busy` = 0.
  - Buffer contents after reset are don't-care.
- `in_ready` is 1 from the first cycle after `rst` deasserts.
- Last input accept at edge T: CLR during cycle T+1, FIRE (`attn_start`) during T+2, WAIT from T+3.
- `attn_done` sampled high at edge D: `out_valid`=1 from cycle D+1 with token 0.
- Zero-bubble drain: with `out_ready` held high, SEQ_LEN consecutive beats.
- Last output handshake at edge E: `in_ready`=1 in cycle E+1.
- Reset mid-operation: in any state, `rst` aborts within the same edge. No partial output beat follows reset.
- `attn_done` already high on WAIT entry (engine misbehaving): accepted as completion in the first WAIT cycle.

## Structure
- Shared package `attn_pkg`:
  - `bridge_state_e` enum (LOAD, CLR, FIRE, WAIT, DRAIN).
  - `TOKEN_W = DATA_WIDTH*EMBED_DIM`.
  - Default DATA_WIDTH/SEQ_LEN/EMBED_DIM constants shared with the engine.
- No sub-module: FSM, two index counters, watchdog and two flat buffers in one module.

## Test plan
Bench params: SEQ_LEN=4, EMBED_DIM=2, DATA_WIDTH=16, TIMEOUT=16. Behavioral engine model returns each element+1 eight cycles after `attn_start`.

- Basic round trip:
  - Stimulus: tokens {0x0001,0x0002}…{0x0007,0x0008} with `in_valid` always high and `out_ready` always high.
  - Response: outputs {0x0002,0x0003}…{0x0008,0x0009}; `out_last` only on the 4th beat.
  - Response: `attn_rst` pulses at T+1 and `attn_start` at T+2, one cycle each.
- Input gaps:
  - Stimulus: `in_valid` toggled 1/0 each cycle.
  - Response: exactly 4 accepts, packed in order; `attn_start` only after the 4th accept.
- Output backpressure:
  - Stimulus: `out_ready` low for 5 cycles at beat 2.
  - Response: `out_token` and `out_valid` held stable, no beat lost or duplicated, `in_ready`=0 until the last beat.
- Timeout:
  - Stimulus: engine model never raises done.
  - Response: `timeout_err`=1 16 cycles after WAIT entry, state back to LOAD, no `out_valid`.
  - Response: the next sequence processes normally with `timeout_err` still 1.
- Reset mid-DRAIN:
  - Stimulus: assert `rst` after beat 1.
  - Response: next cycle `out_valid`=0, `in_ready`=1 after deassert, `attn_rst`=1 during `rst`.
- Back-to-back sequences:
  - Stimulus: two sequences with engine done left sticky between them.
  - Response: the second run waits for its own done, because CLR clears the stale done and `attn_rst` pulses again.
